// File: rtl/branch_resolve_pkg.sv
// rtl/branch_resolve_pkg.sv - shared pipeline definitions: predictor counter encodings and PPCCB fields
package branch_resolve_pkg;

   typedef enum logic [1:0] {
      CB_SNT = 2'b00,
      CB_WNT = 2'b01,
      CB_WT  = 2'b10,
      CB_ST  = 2'b11
   } cb_t;

   typedef enum logic {
      ST_RESOLVE = 1'b0,
      ST_SHADOW  = 1'b1
   } br_state_t;

   localparam int PPC_MSB = 31;
   localparam int PPC_LSB = 0;
   localparam int CB_MSB  = 33;
   localparam int CB_LSB  = 32;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating branch predictor counter update
module sat_counter2
   import branch_resolve_pkg::*;
(
   input  logic [1:0] cb,
   input  logic       taken,
   output logic [1:0] cb_next
);

   always_comb begin
      cb_next = cb;
      if (taken) begin
         if (cb != CB_ST) cb_next = cb + 2'd1;
      end else begin
         if (cb != CB_SNT) cb_next = cb - 2'd1;
      end
   end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch resolution: redirect/flush, BTB update and branch statistics
module branch_resolve
   import branch_resolve_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Valid,
   input  logic        IsBranch,
   input  logic        Taken,
   input  logic [31:0] TargetAddr,
   input  logic [31:0] InstrAddr,
   input  logic [31:0] PC,
   input  logic [33:0] PPCCB,
   input  logic        PCMatch,
   input  logic        EX_Stall,
   output logic        FlushPipeandPC,
   output logic        WriteEnable,
   output logic [1:0]  CB_o,
   output logic [31:0] JmpAddr,
   output logic [31:0] JmpInstrAddr,
   output logic [31:0] BranchCount,
   output logic [31:0] MispredictCount
);

   br_state_t   state_q, state_d;
   logic        flush_q, flush_d;
   logic        we_q, we_d;
   logic [1:0]  cb_q, cb_d;
   logic [31:0] jmp_addr_q, jmp_addr_d;
   logic [31:0] jmp_instr_addr_q, jmp_instr_addr_d;
   logic [31:0] branch_count_q, branch_count_d;
   logic [31:0] mispredict_count_q, mispredict_count_d;

   logic        resolve;
   logic        mispredict;
   logic        btb_write;
   logic [31:0] actual_next;
   logic [31:0] pred_next;
   logic [1:0]  cb_hit_next;

   sat_counter2 u_sat_counter2 (
      .cb      (PPCCB[CB_MSB:CB_LSB]),
      .taken   (Taken),
      .cb_next (cb_hit_next)
   );

   always_comb begin
      resolve     = Valid & IsBranch & ~EX_Stall & (state_q == ST_RESOLVE);
      actual_next = Taken ? TargetAddr : PC;
      pred_next   = PCMatch ? PPCCB[PPC_MSB:PPC_LSB] : PC;
      mispredict  = resolve & (actual_next != pred_next);
      // A not-taken miss matches the fall-through prediction, so it never allocates.
      btb_write   = resolve & (PCMatch | Taken);

      state_d            = state_q;
      flush_d            = mispredict;
      we_d               = btb_write;
      cb_d               = cb_q;
      jmp_addr_d         = jmp_addr_q;
      jmp_instr_addr_d   = jmp_instr_addr_q;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;

      if (btb_write || mispredict) begin
         cb_d             = PCMatch ? cb_hit_next : CB_WT;
         jmp_addr_d       = actual_next;
         jmp_instr_addr_d = InstrAddr;
      end
      if (resolve)    branch_count_d     = branch_count_q + 32'd1;
      if (mispredict) mispredict_count_d = mispredict_count_q + 32'd1;

      // The shadow slot holds the wrong-path instruction; it always lasts one cycle.
      case (state_q)
         ST_RESOLVE: if (mispredict) state_d = ST_SHADOW;
         ST_SHADOW:  state_d = ST_RESOLVE;
         default:    state_d = ST_RESOLVE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q            <= ST_RESOLVE;
         flush_q            <= 1'b0;
         we_q               <= 1'b0;
         cb_q               <= 2'b00;
         jmp_addr_q         <= 32'd0;
         jmp_instr_addr_q   <= 32'd0;
         branch_count_q     <= 32'd0;
         mispredict_count_q <= 32'd0;
      end else begin
         state_q            <= state_d;
         flush_q            <= flush_d;
         we_q               <= we_d;
         cb_q               <= cb_d;
         jmp_addr_q         <= jmp_addr_d;
         jmp_instr_addr_q   <= jmp_instr_addr_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign FlushPipeandPC  = flush_q;
   assign WriteEnable     = we_q;
   assign CB_o            = cb_q;
   assign JmpAddr         = jmp_addr_q;
   assign JmpInstrAddr    = jmp_instr_addr_q;
   assign BranchCount     = branch_count_q;
   assign MispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve
module tb_branch_resolve;

   logic        Clk = 1'b0;
   logic        Rst, Valid, IsBranch, Taken, PCMatch, EX_Stall;
   logic [31:0] TargetAddr, InstrAddr, PC;
   logic [33:0] PPCCB;
   logic        FlushPipeandPC, WriteEnable;
   logic [1:0]  CB_o;
   logic [31:0] JmpAddr, JmpInstrAddr, BranchCount, MispredictCount;

   int n_cmp = 0;
   int n_fail = 0;

   // reference model state
   logic        m_shadow = 1'b0;
   logic        e_flush = 1'b0, e_we = 1'b0;
   logic [1:0]  e_cb = 2'b00;
   logic [31:0] e_jmp = 32'd0, e_jia = 32'd0, e_bc = 32'd0, e_mc = 32'd0;

   branch_resolve dut (
      .Clk(Clk), .Rst(Rst), .Valid(Valid), .IsBranch(IsBranch), .Taken(Taken),
      .TargetAddr(TargetAddr), .InstrAddr(InstrAddr), .PC(PC), .PPCCB(PPCCB),
      .PCMatch(PCMatch), .EX_Stall(EX_Stall),
      .FlushPipeandPC(FlushPipeandPC), .WriteEnable(WriteEnable), .CB_o(CB_o),
      .JmpAddr(JmpAddr), .JmpInstrAddr(JmpInstrAddr),
      .BranchCount(BranchCount), .MispredictCount(MispredictCount)
   );

   always #5 Clk = ~Clk;

   task automatic model_step();
      logic        ev, mis, wr;
      logic [31:0] actual, pred;
      int          c;
      if (Rst) begin
         m_shadow = 0; e_flush = 0; e_we = 0; e_cb = 0;
         e_jmp = 0; e_jia = 0; e_bc = 0; e_mc = 0;
         return;
      end
      ev     = Valid && IsBranch && !EX_Stall && !m_shadow;
      actual = Taken ? TargetAddr : PC;
      pred   = PCMatch ? PPCCB[31:0] : PC;
      mis    = ev && (actual != pred);
      wr     = ev && (PCMatch || Taken);
      e_flush = mis;
      e_we    = wr;
      if (wr) begin
         c = int'(PPCCB[33:32]);
         if (!PCMatch) c = 2;
         else if (Taken) c = (c == 3) ? 3 : c + 1;
         else c = (c == 0) ? 0 : c - 1;
         e_cb  = c[1:0];
         e_jmp = actual;
         e_jia = InstrAddr;
      end
      if (ev) e_bc = e_bc + 1;
      if (mis) e_mc = e_mc + 1;
      m_shadow = mis;
   endtask

   task automatic drive(input logic v, input logic br, input logic tk, input logic [31:0] tgt,
                        input logic [31:0] ia, input logic [31:0] pc, input logic [1:0] cb,
                        input logic [31:0] ppc, input logic hit, input logic stall, input logic rst);
      Valid = v; IsBranch = br; Taken = tk; TargetAddr = tgt; InstrAddr = ia; PC = pc;
      PPCCB = {cb, ppc}; PCMatch = hit; EX_Stall = stall; Rst = rst;
      model_step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 32'h0, 32'h0, 32'h0, 2'b00, 32'h0, 0, 0, 0);
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      drive(1, 1, 1, 32'h10, 32'h4, 32'h8, 2'b01, 32'h0, 1, 0, 1);
      n_cmp++;
      if ({FlushPipeandPC, WriteEnable, CB_o, JmpAddr, JmpInstrAddr, BranchCount, MispredictCount} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: flush=%0b we=%0b cb=%0h jmp=%0h jia=%0h bc=%0h mc=%0h, want all 0",
                  FlushPipeandPC, WriteEnable, CB_o, JmpAddr, JmpInstrAddr, BranchCount, MispredictCount);
      end
   endtask

   task automatic test_hit_taken();
      drive(1, 1, 1, 32'h100, 32'hC, 32'h10, 2'b01, 32'h100, 1, 0, 0);
      n_cmp++;
      if ({WriteEnable, CB_o, FlushPipeandPC, JmpAddr} !== {1'b1, 2'b10, 1'b0, 32'h100}) begin
         n_fail++;
         $display("FAIL hit_taken: we=%0b cb=%0h flush=%0b jmp=%0h, want 1 2 0 100",
                  WriteEnable, CB_o, FlushPipeandPC, JmpAddr);
      end
      n_cmp++;
      if (BranchCount !== 32'd1 || MispredictCount !== 32'd0) begin
         n_fail++;
         $display("FAIL hit_taken_counts: bc=%0d mc=%0d, want 1 0", BranchCount, MispredictCount);
      end
      idle();
      n_cmp++;
      if ({WriteEnable, FlushPipeandPC, CB_o, JmpAddr, JmpInstrAddr} !== {1'b0, 1'b0, 2'b10, 32'h100, 32'hC}) begin
         n_fail++;
         $display("FAIL hold_after_pulse: we=%0b flush=%0b cb=%0h jmp=%0h jia=%0h, want 0 0 2 100 c",
                  WriteEnable, FlushPipeandPC, CB_o, JmpAddr, JmpInstrAddr);
      end
   endtask

   task automatic test_mispredict_shadow();
      logic [31:0] mc0, bc0;
      mc0 = e_mc; bc0 = e_bc;
      drive(1, 1, 0, 32'h80, 32'h40, 32'h44, 2'b11, 32'h80, 1, 0, 0);
      n_cmp++;
      if ({FlushPipeandPC, WriteEnable, JmpAddr, CB_o} !== {1'b1, 1'b1, 32'h44, 2'b10} || MispredictCount !== mc0 + 1) begin
         n_fail++;
         $display("FAIL mispredict_hit: flush=%0b we=%0b jmp=%0h cb=%0h mc=%0d, want 1 1 44 2 %0d",
                  FlushPipeandPC, WriteEnable, JmpAddr, CB_o, MispredictCount, mc0 + 1);
      end
      drive(1, 1, 1, 32'h900, 32'h44, 32'h48, 2'b00, 32'h0, 0, 0, 0);
      n_cmp++;
      if ({FlushPipeandPC, WriteEnable} !== 2'b00 || BranchCount !== bc0 + 1 || JmpAddr !== 32'h44) begin
         n_fail++;
         $display("FAIL shadow_ignored: flush=%0b we=%0b bc=%0d jmp=%0h, want 0 0 %0d 44",
                  FlushPipeandPC, WriteEnable, BranchCount, bc0 + 1, JmpAddr);
      end
   endtask

   task automatic test_miss_and_saturate();
      logic [31:0] bc0;
      drive(1, 1, 1, 32'h200, 32'h20, 32'h24, 2'b00, 32'h0, 0, 0, 0);
      n_cmp++;
      if ({WriteEnable, FlushPipeandPC, CB_o, JmpInstrAddr, JmpAddr} !== {1'b1, 1'b1, 2'b10, 32'h20, 32'h200}) begin
         n_fail++;
         $display("FAIL miss_taken: we=%0b flush=%0b cb=%0h jia=%0h jmp=%0h, want 1 1 2 20 200",
                  WriteEnable, FlushPipeandPC, CB_o, JmpInstrAddr, JmpAddr);
      end
      idle();
      bc0 = e_bc;
      drive(1, 1, 0, 32'h300, 32'h30, 32'h34, 2'b00, 32'h0, 0, 0, 0);
      n_cmp++;
      if ({WriteEnable, FlushPipeandPC} !== 2'b00 || BranchCount !== bc0 + 1 || CB_o !== 2'b10) begin
         n_fail++;
         $display("FAIL miss_not_taken: we=%0b flush=%0b bc=%0d cb=%0h, want 0 0 %0d 2",
                  WriteEnable, FlushPipeandPC, BranchCount, CB_o, bc0 + 1);
      end
      drive(1, 1, 0, 32'h500, 32'h50, 32'h54, 2'b00, 32'h54, 1, 0, 0);
      n_cmp++;
      if ({WriteEnable, FlushPipeandPC, CB_o} !== {1'b1, 1'b0, 2'b00}) begin
         n_fail++;
         $display("FAIL sat_floor: we=%0b flush=%0b cb=%0h, want 1 0 0", WriteEnable, FlushPipeandPC, CB_o);
      end
      drive(1, 1, 1, 32'h600, 32'h60, 32'h64, 2'b11, 32'h600, 1, 0, 0);
      n_cmp++;
      if ({WriteEnable, FlushPipeandPC, CB_o} !== {1'b1, 1'b0, 2'b11}) begin
         n_fail++;
         $display("FAIL sat_cap: we=%0b flush=%0b cb=%0h, want 1 0 3", WriteEnable, FlushPipeandPC, CB_o);
      end
   endtask

   task automatic test_stall();
      logic [31:0] bc0;
      int          pulses;
      bc0 = e_bc; pulses = 0;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, 32'h700, 32'h70, 32'h74, 2'b01, 32'h700, 1, 1, 0);
         if (WriteEnable || FlushPipeandPC || BranchCount !== bc0) pulses++;
      end
      n_cmp++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL stall_hold: %0d cycles with activity, want 0", pulses);
      end
      drive(1, 1, 1, 32'h700, 32'h70, 32'h74, 2'b01, 32'h700, 1, 0, 0);
      n_cmp++;
      if (BranchCount !== bc0 + 1 || WriteEnable !== 1'b1 || CB_o !== 2'b10) begin
         n_fail++;
         $display("FAIL stall_release: bc=%0d we=%0b cb=%0h, want %0d 1 2", BranchCount, WriteEnable, CB_o, bc0 + 1);
      end
      idle();
      n_cmp++;
      if (BranchCount !== bc0 + 1 || WriteEnable !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_once: bc=%0d we=%0b, want %0d 0", BranchCount, WriteEnable, bc0 + 1);
      end
   endtask

   task automatic test_reset_cancel();
      drive(1, 1, 0, 32'h80, 32'h40, 32'h44, 2'b11, 32'h80, 1, 0, 0);
      n_cmp++;
      if (FlushPipeandPC !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_flush: flush=%0b, want 1", FlushPipeandPC);
      end
      drive(1, 1, 0, 32'h80, 32'h40, 32'h44, 2'b11, 32'h80, 1, 0, 1);
      n_cmp++;
      if ({FlushPipeandPC, WriteEnable, BranchCount, MispredictCount} !== '0) begin
         n_fail++;
         $display("FAIL reset_cancel: flush=%0b we=%0b bc=%0d mc=%0d, want 0 0 0 0",
                  FlushPipeandPC, WriteEnable, BranchCount, MispredictCount);
      end
      drive(1, 1, 0, 32'h80, 32'h40, 32'h44, 2'b11, 32'h80, 1, 0, 0);
      n_cmp++;
      if (FlushPipeandPC !== 1'b1 || BranchCount !== 32'd1 || MispredictCount !== 32'd1) begin
         n_fail++;
         $display("FAIL resolve_after_reset: flush=%0b bc=%0d mc=%0d, want 1 1 1",
                  FlushPipeandPC, BranchCount, MispredictCount);
      end
      idle();
   endtask

   task automatic test_random();
      logic        v, br, tk, hit, st, rs;
      logic [31:0] tgt, pc, ppc;
      int          sel;
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 9) < 8);
         br  = ($urandom_range(0, 9) < 7);
         tk  = $urandom_range(0, 1);
         hit = $urandom_range(0, 1);
         st  = ($urandom_range(0, 5) == 0);
         rs  = ($urandom_range(0, 59) == 0);
         tgt = {$urandom_range(0, 255), 2'b00};
         pc  = {$urandom_range(0, 255), 2'b00};
         sel = $urandom_range(0, 2);
         ppc = (sel == 0) ? tgt : (sel == 1) ? pc : $urandom;
         drive(v, br, tk, tgt, pc - 32'd4, pc, 2'($urandom_range(0, 3)), ppc, hit, st, rs);
         n_cmp++;
         if ({FlushPipeandPC, WriteEnable, CB_o, JmpAddr, JmpInstrAddr, BranchCount, MispredictCount} !==
             {e_flush, e_we, e_cb, e_jmp, e_jia, e_bc, e_mc}) begin
            n_fail++;
            $display("FAIL random[%0d]: got fl=%0b we=%0b cb=%0h jmp=%0h jia=%0h bc=%0d mc=%0d want fl=%0b we=%0b cb=%0h jmp=%0h jia=%0h bc=%0d mc=%0d",
                     i, FlushPipeandPC, WriteEnable, CB_o, JmpAddr, JmpInstrAddr, BranchCount, MispredictCount,
                     e_flush, e_we, e_cb, e_jmp, e_jia, e_bc, e_mc);
         end
      end
   endtask

   initial begin
      test_reset();
      test_hit_taken();
      test_mispredict_shadow();
      test_miss_and_saturate();
      test_stall();
      test_reset_cancel();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: Clk input 1 (rising edge); Rst input 1 (synchronous, active-high).
REQ-002 SHALL have input Valid, 1 bit: EX-stage instruction is valid (not a bubble).
REQ-003 SHALL have input IsBranch, 1 bit: EX-stage instruction is a conditional branch.
REQ-004 SHALL have input Taken, 1 bit: resolved branch outcome.
REQ-005 SHALL have input TargetAddr, 32 bits: resolved branch target.
REQ-006 SHALL have input InstrAddr, 32 bits: address of the EX-stage instruction.
REQ-007 SHALL have input PC, 32 bits: fall-through address carried from fetch.
REQ-008 SHALL have input PPCCB, 34 bits: [33:32] predictor counter at fetch; [31:0] predicted next PC.
REQ-009 SHALL have input PCMatch, 1 bit: BTB hit at fetch.
REQ-010 SHALL have input EX_Stall, 1 bit: EX stage held this cycle.
REQ-011 SHALL have output FlushPipeandPC, 1 bit: one-cycle redirect and flush pulse.
REQ-012 SHALL have output WriteEnable, 1 bit: one-cycle BTB write pulse.
REQ-013 SHALL have output CB_o, 2 bits: new counter value for the BTB entry.
REQ-014 SHALL have output JmpAddr, 32 bits: corrected next PC (redirect) and BTB target.
REQ-015 SHALL have output JmpInstrAddr, 32 bits: BTB index/tag address (branch InstrAddr).
REQ-016 SHALL have output BranchCount, 32 bits: number of resolved branches.
REQ-017 SHALL have output MispredictCount, 32 bits: number of mispredicted branches.

Function
REQ-018 A resolution event SHALL occur when Valid & IsBranch & !EX_Stall & (state == RESOLVE).
REQ-019 ActualNext SHALL be TargetAddr if Taken, else PC.
REQ-020 PredNext SHALL be PPCCB[31:0] if PCMatch, else PC.
REQ-021 Mispredict SHALL be (ActualNext != PredNext) on a resolution event.
REQ-022 Counter update on a BTB hit SHALL saturate: Taken increments (cap 2'b11); not taken decrements (floor 2'b00).
REQ-023 On a BTB miss with Taken, the entry SHALL be allocated with CB_o = 2'b10; on a miss with not taken, no write SHALL occur.
REQ-024 All outputs SHALL be registered, with one-cycle latency from the resolution event.
REQ-025 WriteEnable SHALL pulse for every hit resolution and every taken-miss resolution; JmpAddr = ActualNext and JmpInstrAddr = InstrAddr in the same cycle.
REQ-026 FlushPipeandPC SHALL pulse for exactly one cycle iff Mispredict; it MAY coincide with WriteEnable.
REQ-027 Outside pulse cycles, FlushPipeandPC and WriteEnable SHALL be 0; JmpAddr, JmpInstrAddr and CB_o SHALL hold their last values.
REQ-028 FSM states SHALL be RESOLVE and SHADOW:
- RESOLVE -> SHADOW on a mispredict.
- SHADOW -> RESOLVE unconditionally after one cycle.
- In SHADOW, no resolution, counting or pulse SHALL occur (the wrong-path instruction is ignored).
REQ-029 BranchCount SHALL increment per resolution event; MispredictCount SHALL increment per mispredict; both SHALL wrap modulo 2^32.
REQ-030 While EX_Stall is high, no event SHALL be taken and the FSM state SHALL be held, except that SHADOW SHALL still exit after one cycle.

Reset
REQ-031 While Rst is high at a clock edge:
- all outputs SHALL be 0 and the state SHALL be RESOLVE;
- a resolution in the same cycle SHALL be discarded;
- a flush or write pulse due next cycle SHALL be cancelled.

Structure
REQ-032 The counter encodings SNT=00, WNT=01, WT=10, ST=11 and the PPCCB field ranges (PPC [31:0], CB [33:32]) SHALL live in the shared pipeline definitions package used by the fetch stage.
REQ-033 The 2-bit saturating update SHALL be a sub-module named sat_counter2 (inputs cb, taken; output cb_next).

Verification
REQ-034 Hit, CB=01, Taken=1, TargetAddr=0x100, PPC=0x100 -> next cycle: WriteEnable=1, CB_o=10, FlushPipeandPC=0, JmpAddr=0x100.
REQ-035 Hit, CB=11, Taken=0, PC=0x44, PPC=0x80 -> FlushPipeandPC=1 for one cycle, JmpAddr=0x44, CB_o=10, MispredictCount+1; a Valid branch on the following cycle is ignored.
REQ-036 Miss, Taken=1, InstrAddr=0x20, TargetAddr=0x200 -> WriteEnable=1, FlushPipeandPC=1, CB_o=10, JmpInstrAddr=0x20, JmpAddr=0x200.
REQ-037 Miss, Taken=0 -> no pulses; BranchCount+1; CB=00 not-taken and CB=11 taken hits -> CB_o saturates at 00/11.
REQ-038 EX_Stall=1 with a valid branch for 3 cycles -> no pulses and no count change; resolution occurs exactly once after the stall is released.
REQ-039 Mispredict resolved, Rst=1 on the next edge -> FlushPipeandPC=0, both counts 0, state RESOLVE; MispredictCount preset near 0xFFFFFFFF wraps to 0.
